timer_slave_ip: RTL

TIMER_SLAVE_IP -- requirements
Module: timer_slave_ip

---
 rtl/timer_slave_ip.sv | 74 +++++++
 1 files changed

// File: rtl/timer_slave_ip.sv
// timer_slave_ip: memory-mapped prescaled up-counter with compare match,
// overflow detection, write-1-to-clear status and a level interrupt.
module timer_slave_ip #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
);
    logic [2:0]            ctrl_q, ctrl_d;
    logic [15:0]           prescale_q, prescale_d, psc_q, psc_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d, count_q, count_d;
    logic [1:0]            status_q, status_d;
    logic [2:0]            sel;
    logic                  wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_sts;
    logic                  tick, hit, ovf_set;
    logic                  unused_addr;

    assign sel         = address[4:2];
    assign unused_addr = ^{address[31:5], address[1:0]};
    assign wr_ctrl     = we && sel == 3'd0;
    assign wr_pre      = we && sel == 3'd1;
    assign wr_cmp      = we && sel == 3'd2;
    assign wr_cnt      = we && sel == 3'd3;
    assign wr_sts      = we && sel == 3'd4;

    // A software load of COUNT wins over the tick, so no flags can be raised by it.
    always_comb begin
        tick       = ctrl_q[0] && psc_q == prescale_q;
        hit        = tick && !wr_cnt && count_q == compare_q;
        ovf_set    = tick && !wr_cnt && &count_q && !(hit && ctrl_q[1]);
        ctrl_d     = wr_ctrl ? wd[2:0] : ctrl_q;
        prescale_d = wr_pre ? wd[15:0] : prescale_q;
        compare_d  = wr_cmp ? wd : compare_q;
        psc_d      = (wr_ctrl || wr_pre || !ctrl_q[0] || tick) ? 16'd0 : psc_q + 16'd1;
        count_d    = wr_cnt ? wd :
                     !tick ? count_q :
                     (hit && ctrl_q[1]) ? '0 : count_q + DATA_WIDTH'(1);
        status_d   = (status_q & ~(wr_sts ? wd[1:0] : 2'b00)) | {ovf_set, hit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= '1;
            count_q    <= '0;
            status_q   <= '0;
            psc_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            status_q   <= status_d;
            psc_q      <= psc_d;
        end
    end

    always_comb begin
        rd  = !re ? '0 :
              sel == 3'd0 ? DATA_WIDTH'(ctrl_q) :
              sel == 3'd1 ? DATA_WIDTH'(prescale_q) :
              sel == 3'd2 ? compare_q :
              sel == 3'd3 ? count_q :
              sel == 3'd4 ? DATA_WIDTH'(status_q) : '0;
        irq = status_q[0] & ctrl_q[2];
    end
endmodule
